// File: rtl/alu_pkg.sv
// Shared opcode encodings and datapath width for alu16, its checker and benches.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;

  localparam logic [3:0] OP_LEGAL_MAX = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_LEGAL_MAX;
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of alu16: y, carry and zero from a, b and op.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
  output logic [WIDTH-1:0] o_y,
  output logic             o_carry,
  output logic             o_zero
);

  logic [WIDTH:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};

  // Illegal opcodes yield zeros; the checker never compares them.
  always_comb begin
    o_y     = '0;
    o_carry = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_y     = w_sum[WIDTH-1:0];
        o_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        o_y     = i_a - i_b;
        o_carry = (i_a < i_b);
      end
      OP_AND: o_y = i_a & i_b;
      OP_OR:  o_y = i_a | i_b;
      OP_XOR: o_y = i_a ^ i_b;
      OP_NOT: o_y = ~i_a;
      OP_SHL: begin
        o_y     = {i_a[WIDTH-2:0], 1'b0};
        o_carry = i_a[WIDTH-1];
      end
      OP_SHR: begin
        o_y     = {1'b0, i_a[WIDTH-1:1]};
        o_carry = i_a[0];
      end
      default: begin
        o_y     = '0;
        o_carry = 1'b0;
      end
    endcase
  end

  assign o_zero = (o_y == '0);

endmodule

// File: rtl/alu_result_checker.sv
// Streaming self-check for alu16: recomputes each result record, counts records,
// mismatches and illegal ops, and captures the first failing record.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH       = ALU_WIDTH,
  parameter int unsigned NUM_VECTORS = 256,
  parameter int unsigned CNT_W       = 16,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_carry,
  input  logic             in_zero,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] illegal_count,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp_y,
  output logic [WIDTH-1:0] first_err_got_y,
  output logic [3:0]       first_err_flags
);

  localparam int unsigned      ACC_W    = $clog2(NUM_VECTORS + 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = ACC_W'(NUM_VECTORS);
  localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

  chk_state_t r_state;
  chk_state_t w_next_state;

  logic [ACC_W-1:0] r_acc_cnt;
  logic             r_stop_pending;
  logic [CNT_W-1:0] r_vec_count;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_illegal_count;
  logic             r_first_valid;
  logic [CNT_W-1:0] r_first_idx;
  logic [WIDTH-1:0] r_first_exp_y;
  logic [WIDTH-1:0] r_first_got_y;
  logic [3:0]       r_first_flags;

  logic             r_s1_valid;
  logic             r_s1_illegal;
  logic [CNT_W-1:0] r_s1_idx;
  logic [WIDTH-1:0] r_s1_exp_y;
  logic             r_s1_exp_c;
  logic             r_s1_exp_z;
  logic [WIDTH-1:0] r_s1_got_y;
  logic             r_s1_got_c;
  logic             r_s1_got_z;

  logic [WIDTH-1:0] w_exp_y;
  logic             w_exp_c;
  logic             w_exp_z;
  logic             w_start_ok;
  logic             w_accept;
  logic             w_mismatch;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .i_a     (in_a),
    .i_b     (in_b),
    .i_op    (in_op),
    .o_y     (w_exp_y),
    .o_carry (w_exp_c),
    .o_zero  (w_exp_z)
  );

  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign in_ready   = (r_state == ST_RUN) && (r_acc_cnt < ACC_MAX) && !r_stop_pending;
  assign w_accept   = in_valid && in_ready;
  assign w_mismatch = r_s1_valid && !r_s1_illegal &&
                      ((r_s1_exp_y != r_s1_got_y) || (r_s1_exp_c != r_s1_got_c) ||
                       (r_s1_exp_z != r_s1_got_z));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_RUN;
      ST_RUN: begin
        if ((w_accept && (r_acc_cnt == ACC_LAST)) || (STOP_ON_ERR && w_mismatch))
          w_next_state = ST_DRAIN;
      end
      ST_DRAIN: if (!r_s1_valid) w_next_state = ST_DONE;
      ST_DONE:  if (start) w_next_state = ST_RUN;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // S1: capture the received record alongside its golden result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_illegal <= 1'b0;
      r_s1_idx     <= '0;
      r_s1_exp_y   <= '0;
      r_s1_exp_c   <= 1'b0;
      r_s1_exp_z   <= 1'b0;
      r_s1_got_y   <= '0;
      r_s1_got_c   <= 1'b0;
      r_s1_got_z   <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_illegal <= !op_is_legal(in_op);
        r_s1_idx     <= r_vec_count;
        r_s1_exp_y   <= w_exp_y;
        r_s1_exp_c   <= w_exp_c;
        r_s1_exp_z   <= w_exp_z;
        r_s1_got_y   <= in_y;
        r_s1_got_c   <= in_carry;
        r_s1_got_z   <= in_zero;
      end
    end
  end

  // S2: compare and update counters; accept-side and compare-side updates are independent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_cnt       <= '0;
      r_stop_pending  <= 1'b0;
      r_vec_count     <= '0;
      r_err_count     <= '0;
      r_illegal_count <= '0;
      r_first_valid   <= 1'b0;
      r_first_idx     <= '0;
      r_first_exp_y   <= '0;
      r_first_got_y   <= '0;
      r_first_flags   <= '0;
    end else if (w_start_ok) begin
      r_acc_cnt       <= '0;
      r_stop_pending  <= 1'b0;
      r_vec_count     <= '0;
      r_err_count     <= '0;
      r_illegal_count <= '0;
      r_first_valid   <= 1'b0;
      r_first_idx     <= '0;
      r_first_exp_y   <= '0;
      r_first_got_y   <= '0;
      r_first_flags   <= '0;
    end else begin
      if (w_accept) begin
        r_acc_cnt   <= r_acc_cnt + ACC_W'(1);
        r_vec_count <= sat_inc(r_vec_count);
      end
      if (r_s1_valid && r_s1_illegal) r_illegal_count <= sat_inc(r_illegal_count);
      if (w_mismatch) begin
        r_err_count <= sat_inc(r_err_count);
        if (STOP_ON_ERR) r_stop_pending <= 1'b1;
        if (!r_first_valid) begin
          r_first_valid <= 1'b1;
          r_first_idx   <= r_s1_idx;
          r_first_exp_y <= r_s1_exp_y;
          r_first_got_y <= r_s1_got_y;
          r_first_flags <= {r_s1_exp_c, r_s1_got_c, r_s1_exp_z, r_s1_got_z};
        end
      end
    end
  end

  assign busy            = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done            = (r_state == ST_DONE);
  assign pass            = done && (r_err_count == '0);
  assign vec_count       = r_vec_count;
  assign err_count       = r_err_count;
  assign illegal_count   = r_illegal_count;
  assign first_err_valid = r_first_valid;
  assign first_err_idx   = r_first_idx;
  assign first_err_exp_y = r_first_exp_y;
  assign first_err_got_y = r_first_got_y;
  assign first_err_flags = r_first_flags;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: a free-running checker and a stop-on-error one.
module tb_alu_result_checker;

  logic        clk;
  logic        rst;
  logic        start_m;
  logic        start_s;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  in_op;
  logic [15:0] in_y;
  logic        in_carry;
  logic        in_zero;

  logic        in_ready_m, busy_m, done_m, pass_m, fev_m;
  logic [15:0] vec_m, err_m, ill_m, fidx_m, fexp_m, fgot_m;
  logic [3:0]  fflags_m;

  logic        in_ready_s, busy_s, done_s, pass_s, fev_s;
  logic [15:0] vec_s, err_s, ill_s, fidx_s, fexp_s, fgot_s;
  logic [3:0]  fflags_s;

  int n_cmp = 0;
  int n_mis = 0;

  alu_result_checker #(.WIDTH(16), .NUM_VECTORS(256), .CNT_W(16), .STOP_ON_ERR(1'b0)) u_dut (
    .clk (clk), .rst (rst), .start (start_m), .in_valid (in_valid), .in_ready (in_ready_m),
    .in_a (in_a), .in_b (in_b), .in_op (in_op), .in_y (in_y), .in_carry (in_carry),
    .in_zero (in_zero), .busy (busy_m), .done (done_m), .pass (pass_m), .vec_count (vec_m),
    .err_count (err_m), .illegal_count (ill_m), .first_err_valid (fev_m),
    .first_err_idx (fidx_m), .first_err_exp_y (fexp_m), .first_err_got_y (fgot_m),
    .first_err_flags (fflags_m)
  );

  alu_result_checker #(.WIDTH(16), .NUM_VECTORS(16), .CNT_W(16), .STOP_ON_ERR(1'b1)) u_dut_stop (
    .clk (clk), .rst (rst), .start (start_s), .in_valid (in_valid), .in_ready (in_ready_s),
    .in_a (in_a), .in_b (in_b), .in_op (in_op), .in_y (in_y), .in_carry (in_carry),
    .in_zero (in_zero), .busy (busy_s), .done (done_s), .pass (pass_s), .vec_count (vec_s),
    .err_count (err_s), .illegal_count (ill_s), .first_err_valid (fev_s),
    .first_err_idx (fidx_s), .first_err_exp_y (fexp_s), .first_err_got_y (fgot_s),
    .first_err_flags (fflags_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behaves like a correct alu16 to produce the driven results; returns {carry, zero, y}.
  function automatic logic [17:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
    logic [15:0] y;
    logic        c;
    logic [16:0] s;
    y = 16'h0000;
    c = 1'b0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; y = s[15:0]; c = s[16]; end
      4'd1: begin y = a + (~b) + 16'd1; c = (b > a); end
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      4'd5: y = ~a;
      4'd6: begin y = a << 1; c = a[15]; end
      4'd7: begin y = a >> 1; c = a[0]; end
      default: y = 16'h1234;
    endcase
    return {c, (y == 16'h0000), y};
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                      input logic [15:0] y, input logic c, input logic z, input bit gaps);
    int t;
    int n;
    @(negedge clk);
    if (gaps) begin
      n = int'($urandom_range(0, 2));
      repeat (n) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_a = a; in_b = b; in_op = op; in_y = y; in_carry = c; in_zero = z;
    t = 0;
    while (!in_ready_m && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready_m) check_eq("ready_timeout", 32'(in_ready_m), 32'd1);
    @(posedge clk);
  endtask

  // mode 0: a=i, b=255-i, op=i%8. mode 1: same plus boundary records and four op=9 records.
  task automatic send_idx(input int i, input int mode, input int fault_idx,
                          input logic [15:0] fault_y, input bit gaps);
    logic [15:0] a, b, y;
    logic [3:0]  op;
    logic        c, z;
    logic [17:0] r;
    a = 16'(i);
    b = 16'(255 - i);
    op = 4'(i % 8);
    r = alu_model(a, b, op);
    y = r[15:0]; z = r[16]; c = r[17];
    if (mode == 1) begin
      if (i == 0)      begin a = 16'hFFFF; b = 16'h0001; op = 4'd0; y = 16'h0000; c = 1'b1; z = 1'b1; end
      else if (i == 1) begin a = 16'h0000; b = 16'h0001; op = 4'd1; y = 16'hFFFF; c = 1'b1; z = 1'b0; end
      else if (i == 2) begin a = 16'h8000; b = 16'h0000; op = 4'd6; y = 16'h0000; c = 1'b1; z = 1'b1; end
      else if (i == 10 || i == 20 || i == 30 || i == 40) begin
        op = 4'd9; y = 16'hBEEF; c = 1'b1; z = 1'b0;
      end
    end
    if (i == fault_idx) y = fault_y;
    send(a, b, op, y, c, z, gaps);
  endtask

  task automatic pulse_start(input bit stop_dut);
    @(negedge clk);
    if (stop_dut) start_s = 1'b1; else start_m = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    start_m = 1'b0;
  endtask

  task automatic wait_done(input bit stop_dut, input string tag);
    int t;
    t = 0;
    while (!(stop_dut ? done_s : done_m) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq(tag, 32'(stop_dut ? done_s : done_m), 32'd1);
  endtask

  task automatic run_main(input int mode, input int fault_idx, input logic [15:0] fault_y,
                          input bit gaps);
    pulse_start(1'b0);
    check_eq("start_clears_vec", 32'(vec_m), 32'd0);
    check_eq("start_clears_err", 32'(err_m), 32'd0);
    check_eq("start_busy", 32'(busy_m), 32'd1);
    for (int i = 0; i < 256; i++) send_idx(i, mode, fault_idx, fault_y, gaps);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(1'b0, "run_done");
  endtask

  initial begin
    int n_acc;
    logic [17:0] r;
    rst = 1'b1; start_m = 1'b0; start_s = 1'b0; in_valid = 1'b1;
    in_a = 16'h0005; in_b = 16'h0003; in_op = 4'd0; in_y = 16'h0008;
    in_carry = 1'b0; in_zero = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(in_ready_m), 32'd0);
    check_eq("rst_busy_done_pass", 32'({busy_m, done_m, pass_m}), 32'd0);
    rst = 1'b0;

    // Idle with valid high and no start: nothing may be accepted.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_eq("idle_ready", 32'(in_ready_m), 32'd0);
    end
    check_eq("idle_vec", 32'(vec_m), 32'd0);
    check_eq("idle_err", 32'(err_m), 32'd0);
    check_eq("idle_ill", 32'(ill_m), 32'd0);
    check_eq("idle_state", 32'({busy_m, done_m, pass_m}), 32'd0);
    check_eq("idle_first", 32'({fev_m, fidx_m}), 32'd0);
    check_eq("idle_first_y", {fexp_m, fgot_m}, 32'd0);
    check_eq("idle_flags", 32'(fflags_m), 32'd0);
    in_valid = 1'b0;

    // Clean run.
    run_main(0, -1, 16'h0000, 1'b0);
    check_eq("a_pass", 32'(pass_m), 32'd1);
    check_eq("a_vec", 32'(vec_m), 32'd256);
    check_eq("a_err", 32'(err_m), 32'd0);
    check_eq("a_ill", 32'(ill_m), 32'd0);
    check_eq("a_busy", 32'(busy_m), 32'd0);
    check_eq("a_first_valid", 32'(fev_m), 32'd0);

    // Fault at index 17: SUB 17-238 = 0xFF23, driven as 0xFF15.
    run_main(0, 17, 16'hFF15, 1'b0);
    check_eq("b_pass", 32'(pass_m), 32'd0);
    check_eq("b_vec", 32'(vec_m), 32'd256);
    check_eq("b_err", 32'(err_m), 32'd1);
    check_eq("b_first_valid", 32'(fev_m), 32'd1);
    check_eq("b_first_idx", 32'(fidx_m), 32'd17);
    check_eq("b_exp_y", 32'(fexp_m), 32'hFF23);
    check_eq("b_got_y", 32'(fgot_m), 32'hFF15);
    check_eq("b_flags", 32'(fflags_m), 32'b1100);

    // Boundaries plus four illegal ops, with random valid gaps.
    run_main(1, -1, 16'h0000, 1'b1);
    check_eq("c_pass", 32'(pass_m), 32'd1);
    check_eq("c_vec", 32'(vec_m), 32'd256);
    check_eq("c_err", 32'(err_m), 32'd0);
    check_eq("c_ill", 32'(ill_m), 32'd4);
    check_eq("c_first_valid", 32'(fev_m), 32'd0);

    // Stop-on-error checker: fault at index 3 (OR 3|252 = 0x00FF, driven 0x00FE), valid held.
    pulse_start(1'b1);
    n_acc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_a = 16'(i); in_b = 16'(255 - i); in_op = 4'(i % 8);
      r = alu_model(in_a, in_b, in_op);
      in_y = (i == 3) ? 16'h00FE : r[15:0];
      in_zero = r[16]; in_carry = r[17];
      if (!in_ready_s) break;
      @(posedge clk);
      n_acc++;
      @(negedge clk);
    end
    check_eq("s_ready_drop", 32'(n_acc >= 4 && n_acc <= 6), 32'd1);
    wait_done(1'b1, "s_done");
    check_eq("s_ready_after", 32'(in_ready_s), 32'd0);
    in_valid = 1'b0;
    check_eq("s_pass", 32'(pass_s), 32'd0);
    check_eq("s_err", 32'(err_s), 32'd1);
    check_eq("s_vec", 32'(vec_s), 32'(n_acc));
    check_eq("s_first_idx", 32'(fidx_s), 32'd3);
    check_eq("s_exp_y", 32'(fexp_s), 32'h00FF);
    check_eq("s_got_y", 32'(fgot_s), 32'h00FE);
    check_eq("main_ignored", 32'(ill_m), 32'd4);

    // Reset in the middle of a run discards everything.
    pulse_start(1'b0);
    for (int i = 0; i < 50; i++) send_idx(i, 0, 5, 16'h0001, 1'b0);
    @(negedge clk);
    check_eq("mid_vec", 32'(vec_m), 32'd50);
    check_eq("mid_busy", 32'(busy_m), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_vec", 32'(vec_m), 32'd0);
    check_eq("mid_rst_err", 32'(err_m), 32'd0);
    check_eq("mid_rst_state", 32'({busy_m, done_m, pass_m, in_ready_m}), 32'd0);
    check_eq("mid_rst_first", 32'({fev_m, fidx_m}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_rst_idle", 32'({busy_m, in_ready_m, vec_m}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
